// File: rtl/soc_mmio_pkg.sv
// Shared definitions for the SoC memory-mapped peripherals: register offsets,
// responder FSM states and reset constants.
package soc_mmio_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  // All-ones compare keeps the timer interrupt off until software programs it.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } timer_mmio_state_t;

endpackage

// File: rtl/mmio_byte_reg32.sv
// 32-bit register with per-byte write enables and a parameterised reset value.
module mmio_byte_reg32 #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [3:0]  i_wmask,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wmask[b]) r_q[8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/timer_mmio.sv
// MMIO responder for the instruction-count timer: mtime (RO), mtimecmp, msip,
// with a hi-word shadow so a lo-then-hi read of mtime is atomic.
//
// state | meaning
// IDLE  | waiting; a request here is performed and its response registered
// RESP  | mem_resp high for one cycle; held request is not re-sampled
module timer_mmio
  import soc_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  input  logic [63:0] count,
  output logic [63:0] count_max,
  output logic        msip
);

  timer_mmio_state_t r_state, w_state_nxt;

  logic        w_access, w_wr, w_rd, w_in_win;
  logic        w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi, w_sel_mt_lo, w_sel_mt_hi;
  logic [31:0] w_rdata, w_cmp_lo, w_cmp_hi;
  logic [31:0] r_rdata, r_hi_shadow;
  logic        r_shadow_valid, r_msip;
  logic        w_unused;

  assign w_unused = &{1'b0, mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_resp    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read || mem_write) begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        mem_resp    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_in_win     = (mem_addr[31:16] == BASE_ADDR[31:16]);
  assign w_sel_msip   = w_in_win && (mem_addr[15:2] == MSIP_OFF[15:2]);
  assign w_sel_cmp_lo = w_in_win && (mem_addr[15:2] == MTIMECMP_LO_OFF[15:2]);
  assign w_sel_cmp_hi = w_in_win && (mem_addr[15:2] == MTIMECMP_HI_OFF[15:2]);
  assign w_sel_mt_lo  = w_in_win && (mem_addr[15:2] == MTIME_LO_OFF[15:2]);
  assign w_sel_mt_hi  = w_in_win && (mem_addr[15:2] == MTIME_HI_OFF[15:2]);

  // A simultaneous read+write is treated purely as a write: no data, no shadow effect.
  assign w_wr = w_access && mem_write;
  assign w_rd = w_access && mem_read && !mem_write;

  mmio_byte_reg32 #(.RST_VAL(MTIMECMP_RST[31:0])) u_cmp_lo (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr && w_sel_cmp_lo),
    .i_wmask (mem_wmask),
    .i_wdata (mem_wdata),
    .o_q     (w_cmp_lo)
  );

  mmio_byte_reg32 #(.RST_VAL(MTIMECMP_RST[63:32])) u_cmp_hi (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr && w_sel_cmp_hi),
    .i_wmask (mem_wmask),
    .i_wdata (mem_wdata),
    .o_q     (w_cmp_hi)
  );

  assign count_max = {w_cmp_hi, w_cmp_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msip <= 1'b0;
    end else if (w_wr && w_sel_msip && mem_wmask[0]) begin
      r_msip <= mem_wdata[0];
    end
  end

  assign msip = r_msip;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_shadow    <= 32'h0;
      r_shadow_valid <= 1'b0;
    end else if (w_rd && w_sel_mt_lo) begin
      r_hi_shadow    <= count[63:32];
      r_shadow_valid <= 1'b1;
    end else if (w_rd && w_sel_mt_hi) begin
      r_shadow_valid <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    if (w_sel_msip)        w_rdata = {31'h0, r_msip};
    else if (w_sel_cmp_lo) w_rdata = w_cmp_lo;
    else if (w_sel_cmp_hi) w_rdata = w_cmp_hi;
    else if (w_sel_mt_lo)  w_rdata = count[31:0];
    else if (w_sel_mt_hi)  w_rdata = r_shadow_valid ? r_hi_shadow : count[63:32];
  end

  // Only the response cycle carries data; every other cycle reloads zero.
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= 32'h0;
    else     r_rdata <= w_rd ? w_rdata : 32'h0;
  end

  assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_timer_mmio.sv
// Self-checking bench for timer_mmio: directed register-map scenarios, then
// randomized accesses checked against a register-level reference model.
module tb_timer_mmio;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_resp;
  logic [63:0] count, count_max;
  logic        msip;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_cmp;
  logic        m_msip;
  logic [31:0] m_shadow;
  logic        m_valid;

  timer_mmio #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .count     (count),
    .count_max (count_max),
    .msip      (msip)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip   = 1'b0;
    m_shadow = 32'h0;
    m_valid  = 1'b0;
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] m);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (m[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  // Register-map semantics of one access; returns the data a read should see.
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [3:0] mask, input logic [31:0] wd,
                              input logic [63:0] cnt, output logic [31:0] exp_rd);
    logic [15:0] off;
    exp_rd = 32'h0;
    off    = {addr[15:2], 2'b00};
    if (addr[31:16] != BASE[31:16]) return;
    if (wr) begin
      case (off)
        16'h0000: if (mask[0]) m_msip = wd[0];
        16'h4000: m_cmp[31:0]  = merge_bytes(m_cmp[31:0], wd, mask);
        16'h4004: m_cmp[63:32] = merge_bytes(m_cmp[63:32], wd, mask);
        default: ;
      endcase
    end else if (rd) begin
      case (off)
        16'h0000: exp_rd = {31'h0, m_msip};
        16'h4000: exp_rd = m_cmp[31:0];
        16'h4004: exp_rd = m_cmp[63:32];
        16'hBFF8: begin
          exp_rd   = cnt[31:0];
          m_shadow = cnt[63:32];
          m_valid  = 1'b1;
        end
        16'hBFFC: begin
          exp_rd  = m_valid ? m_shadow : cnt[63:32];
          m_valid = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  // One complete bus access; checks latency, single pulse, data and register outputs.
  task automatic do_acc(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wd,
                        input logic [63:0] cnt, output logic [31:0] got);
    logic [31:0] exp;
    int pulses = 0;
    int lat    = 0;
    got = 32'h0;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wmask = mask;
    mem_wdata = wd;
    count     = cnt;
    model_access(rd, wr, addr, mask, wd, cnt, exp);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          got = mem_rdata;
          check_eq("rdata", {32'h0, mem_rdata}, {32'h0, exp});
          check_eq("count_max", count_max, m_cmp);
          check_eq("msip", {63'h0, msip}, {63'h0, m_msip});
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end else begin
        check_eq("rdata_idle_zero", {32'h0, mem_rdata}, 64'h0);
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check_eq("resp_latency", 64'(lat), 64'd1);
    check_eq("resp_pulses", 64'(pulses), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [15:0] offs [9];
    int pulses, first;

    offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
             16'h4008, 16'hBFF4, 16'h8000, 16'h0004};

    rst = 1'b1; mem_addr = '0; mem_read = 0; mem_write = 0;
    mem_wmask = '0; mem_wdata = '0; count = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_count_max", count_max, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("rst_msip", {63'h0, msip}, 64'h0);
    check_eq("rst_resp", {63'h0, mem_resp}, 64'h0);
    check_eq("rst_rdata", {32'h0, mem_rdata}, 64'h0);
    rst = 1'b0;
    model_reset();

    do_acc(1, 0, BASE + 32'h4004, 4'h0, 32'h0, 64'h0, r);
    check_eq("cmp_hi_after_rst", {32'h0, r}, 64'hFFFF_FFFF);

    do_acc(0, 1, BASE + 32'h4000, 4'b0011, 32'h1234_5678, 64'h0, r);
    check_eq("cmp_lo_bytemask", {32'h0, count_max[31:0]}, 64'hFFFF_5678);

    do_acc(1, 0, BASE + 32'hBFF8, 4'h0, 32'h0, 64'h0000_0001_FFFF_FFFF, r);
    check_eq("mtime_lo", {32'h0, r}, 64'hFFFF_FFFF);
    do_acc(1, 0, BASE + 32'hBFFC, 4'h0, 32'h0, 64'h0000_0002_0000_0005, r);
    check_eq("mtime_hi_shadow", {32'h0, r}, 64'h1);
    do_acc(1, 0, BASE + 32'hBFFC, 4'h0, 32'h0, 64'h0000_0002_0000_0005, r);
    check_eq("mtime_hi_live", {32'h0, r}, 64'h2);

    do_acc(0, 1, BASE, 4'h1, 32'h1, 64'h0, r);
    check_eq("msip_set", {63'h0, msip}, 64'h1);
    do_acc(0, 1, BASE, 4'h0, 32'h0, 64'h0, r);
    check_eq("msip_nomask", {63'h0, msip}, 64'h1);
    do_acc(0, 1, BASE, 4'h1, 32'h0, 64'h0, r);
    check_eq("msip_clear", {63'h0, msip}, 64'h0);

    do_acc(1, 0, BASE + 32'h8000, 4'h0, 32'h0, 64'h0, r);
    check_eq("unmapped_read", {32'h0, r}, 64'h0);
    do_acc(1, 0, BASE + 32'h1_4000, 4'h0, 32'h0, 64'h0, r);
    check_eq("out_of_window_read", {32'h0, r}, 64'h0);
    do_acc(0, 1, BASE + 32'hBFF8, 4'hF, 32'hDEAD_BEEF, 64'h0000_0007_0000_0009, r);
    do_acc(1, 0, BASE + 32'hBFF8, 4'h0, 32'h0, 64'h0000_0007_0000_0009, r);
    check_eq("mtime_write_ignored", {32'h0, r}, 64'h9);
    do_acc(1, 1, BASE + 32'h4004, 4'hF, 32'h0000_00AB, 64'h0, r);
    check_eq("rw_both_rdata", {32'h0, r}, 64'h0);
    check_eq("rw_both_write", {32'h0, count_max[63:32]}, 64'hAB);

    // Request held across the response cycle must not be re-sampled there.
    @(negedge clk);
    mem_read = 1'b1; mem_addr = BASE + 32'h4000; pulses = 0; first = 0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    mem_read = 1'b0;
    for (int i = 3; i <= 4; i++) begin
      @(negedge clk);
      if (mem_resp) pulses++;
    end
    check_eq("held_read_pulses", 64'(pulses), 64'd1);
    check_eq("held_read_cycle", 64'(first), 64'd1);

    do_acc(1, 0, BASE + 32'hBFF8, 4'h0, 32'h0, 64'h0000_0055_0000_0001, r);
    do_acc(0, 1, BASE, 4'h1, 32'h1, 64'h0, r);
    @(negedge clk);
    mem_write = 1'b1; mem_addr = BASE + 32'h4000; mem_wmask = 4'hF; mem_wdata = 32'h0;
    @(negedge clk);
    check_eq("resp_before_rst", {63'h0, mem_resp}, 64'h1);
    rst = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_resp", {63'h0, mem_resp}, 64'h0);
    check_eq("rst_mid_count_max", count_max, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("rst_mid_msip", {63'h0, msip}, 64'h0);
    rst = 1'b0;
    model_reset();
    do_acc(1, 0, BASE + 32'hBFFC, 4'h0, 32'h0, 64'h0000_0066_0000_0001, r);
    check_eq("shadow_cleared_by_rst", {32'h0, r}, 64'h66);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [63:0] c;
      int op;
      a = BASE | {16'h0, offs[$urandom_range(0, 8)]} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a[31:16] = a[31:16] ^ 16'($urandom_range(1, 16'hFFFF));
      c = {32'($urandom_range(0, 3)), $urandom()};
      op = $urandom_range(0, 6);
      do_acc(op <= 3, op >= 4, a, 4'($urandom_range(0, 15)), $urandom(), c, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
